// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: NREQ execute units onto NPORT regfile write ports.
// Optional branch-kill squash of requests is enabled with `define WBARB_KILL_EN.
module wb_arbiter #(
  parameter int NREQ      = 4,
  parameter int NPORT     = 2,
  parameter int WIDTH_REG = 7,
  parameter int WIDTH_BRM = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_en,
  input  logic [NREQ-1:0]            i_req_valid,
  input  logic [NREQ*WIDTH_REG-1:0]  i_req_addr,
  input  logic [NREQ*32-1:0]         i_req_data,
`ifdef WBARB_KILL_EN
  input  logic [NREQ*WIDTH_BRM-1:0]  i_req_brmask,
  input  logic [WIDTH_BRM-1:0]       i_brkill,
`endif
  output logic [NREQ-1:0]            o_req_ready,
  output logic [NPORT-1:0]           o_we,
  output logic [NPORT*WIDTH_REG-1:0] o_waddr,
  output logic [NPORT*32-1:0]        o_wdata,
  output logic [NPORT*WIDTH_REG-1:0] o_wdest
);

  localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [RRW-1:0]             rr_q, rr_d;
  logic [NPORT-1:0]           we_q, we_d;
  logic [NPORT*WIDTH_REG-1:0] waddr_q, waddr_d;
  logic [NPORT*32-1:0]        wdata_q, wdata_d;
  logic [NREQ-1:0]            grant;
  logic [NREQ-1:0]            kill;
  logic [NPORT-1:0]           pvld;
  logic [RRW-1:0]             psel [NPORT];
  int                         cnt;
  int                         idx;

`ifdef WBARB_KILL_EN
  always_comb begin
    kill = '0;
    for (int r = 0; r < NREQ; r++) begin
      kill[r] = i_req_valid[r] &
        (|(i_req_brmask[r*WIDTH_BRM +: WIDTH_BRM] & i_brkill));
    end
  end
`else
  assign kill = '0;
`endif

  // Scan from rr; k-th live requester in scan order lands on port k
  always_comb begin
    grant = '0;
    pvld  = '0;
    rr_d  = rr_q;
    cnt   = 0;
    idx   = 0;
    for (int k = 0; k < NPORT; k++) psel[k] = '0;
    if (i_en) begin
      for (int i = 0; i < NREQ; i++) begin
        idx = int'(rr_q) + i;
        if (idx >= NREQ) idx = idx - NREQ;
        if (i_req_valid[idx] && !kill[idx] && cnt < NPORT) begin
          grant[idx] = 1'b1;
          pvld[cnt]  = 1'b1;
          psel[cnt]  = idx[RRW-1:0];
          cnt        = cnt + 1;
          rr_d       = (idx == NREQ - 1) ? '0 : RRW'(idx + 1);
        end
      end
    end
  end

  always_comb begin
    we_d    = '0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    for (int k = 0; k < NPORT; k++) begin
      if (pvld[k]) begin
        waddr_d[k*WIDTH_REG +: WIDTH_REG] =
          i_req_addr[int'(psel[k])*WIDTH_REG +: WIDTH_REG];
        wdata_d[k*32 +: 32] = i_req_data[int'(psel[k])*32 +: 32];
        // p0 is hardwired zero: consume the slot but never write it
        we_d[k] = |i_req_addr[int'(psel[k])*WIDTH_REG +: WIDTH_REG];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_q    <= '0;
      we_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      rr_q    <= rr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    o_wdest = '0;
    for (int k = 0; k < NPORT; k++) begin
      if (we_q[k]) begin
        o_wdest[k*WIDTH_REG +: WIDTH_REG] = waddr_q[k*WIDTH_REG +: WIDTH_REG];
      end
    end
  end

  assign o_req_ready = (grant | kill) & {NREQ{i_rst_n}};
  assign o_we        = we_q;
  assign o_waddr     = waddr_q;
  assign o_wdata     = wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model plus directed literal checks.
// Kill scenarios are exercised when WBARB_KILL_EN is defined.
module tb_wb_arbiter;
  localparam int NREQ = 4;
  localparam int NPORT = 2;
  localparam int WR = 7;
  localparam int WB = 3;

  logic                  clk;
  logic                  rst_n;
  logic                  en;
  logic [NREQ-1:0]       valid;
  logic [NREQ*WR-1:0]    raddr;
  logic [NREQ*32-1:0]    rdata;
  logic [NREQ*WB-1:0]    brmask;
  logic [WB-1:0]         brkill;
  logic [NREQ-1:0]       ready;
  logic [NPORT-1:0]      o_we;
  logic [NPORT*WR-1:0]   o_waddr;
  logic [NPORT*32-1:0]   o_wdata;
  logic [NPORT*WR-1:0]   o_wdest;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(
    .NREQ(NREQ), .NPORT(NPORT), .WIDTH_REG(WR), .WIDTH_BRM(WB)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_en(en),
    .i_req_valid(valid),
    .i_req_addr(raddr),
    .i_req_data(rdata),
`ifdef WBARB_KILL_EN
    .i_req_brmask(brmask),
    .i_brkill(brkill),
`endif
    .o_req_ready(ready),
    .o_we(o_we),
    .o_waddr(o_waddr),
    .o_wdata(o_wdata),
    .o_wdest(o_wdest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit killed(input int r);
`ifdef WBARB_KILL_EN
    return valid[r] && ((brmask[r*WB +: WB] & brkill) != 0);
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: state = pointer plus the expected registered ports
  int                  m_rr;
  logic [NPORT-1:0]    m_we;
  logic [NPORT*WR-1:0] m_addr;
  logic [NPORT*32-1:0] m_data;

  initial begin
    int q[$];
    logic [NREQ-1:0]    e_rdy;
    logic [NPORT*WR-1:0] e_dest;
    int r;
    m_rr = 0; m_we = '0; m_addr = '0; m_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_rr = 0; m_we = '0; m_addr = '0; m_data = '0;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_we", 64'(o_we), 64'd0);
        chk("rst_waddr", 64'(o_waddr), 64'd0);
        chk("rst_wdata", 64'(o_wdata), 64'd0);
        chk("rst_wdest", 64'(o_wdest), 64'd0);
      end else begin
        e_dest = '0;
        for (int k = 0; k < NPORT; k++)
          if (m_we[k]) e_dest[k*WR +: WR] = m_addr[k*WR +: WR];
        chk("m_we", 64'(o_we), 64'(m_we));
        chk("m_waddr", 64'(o_waddr), 64'(m_addr));
        chk("m_wdata", 64'(o_wdata), 64'(m_data));
        chk("m_wdest", 64'(o_wdest), 64'(e_dest));
        q.delete();
        e_rdy = '0;
        for (int i = 0; i < NREQ; i++)
          if (killed(i)) e_rdy[i] = 1'b1;
        if (en)
          for (int i = 0; i < NREQ; i++) begin
            r = (m_rr + i) % NREQ;
            if (valid[r] && !killed(r)) q.push_back(r);
          end
        while (q.size() > NPORT) void'(q.pop_back());
        foreach (q[k]) e_rdy[q[k]] = 1'b1;
        chk("m_ready", 64'(ready), 64'(e_rdy));
        for (int k = 0; k < NPORT; k++) begin
          if (k < q.size()) begin
            m_addr[k*WR +: WR] = raddr[q[k]*WR +: WR];
            m_data[k*32 +: 32] = rdata[q[k]*32 +: 32];
            m_we[k] = (raddr[q[k]*WR +: WR] != 0);
          end else begin
            m_we[k] = 1'b0;
          end
        end
        if (q.size() > 0) m_rr = (q[q.size()-1] + 1) % NREQ;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input bit v, input int a,
                         input logic [31:0] d);
    valid[r] = v;
    raddr[r*WR +: WR] = WR'(a);
    rdata[r*32 +: 32] = d;
  endtask

  task automatic all_valid();
    for (int r = 0; r < NREQ; r++)
      set_req(r, 1'b1, 5 + r, 32'h1000 + 32'(r));
  endtask

  initial begin
    rst_n = 1'b1;
    en = 1'b1;
    valid = '0; raddr = '0; rdata = '0;
    brmask = '0; brkill = '0;
    #1 rst_n = 1'b0;
    all_valid();
    repeat (3) step();
    chk("lit_rst_ready", 64'(ready), 64'b0000);
    chk("lit_rst_we", 64'(o_we), 64'b00);
    chk("lit_rst_wdest", 64'(o_wdest), 64'd0);

    rst_n = 1'b1;
    #1 chk("lit_c1_ready", 64'(ready), 64'b0011);
    step();
    chk("lit_c1_we", 64'(o_we), 64'b11);
    chk("lit_c1_waddr", 64'(o_waddr), 64'({7'd6, 7'd5}));
    #1 chk("lit_c2_ready", 64'(ready), 64'b1100);
    step();
    chk("lit_c2_waddr", 64'(o_waddr), 64'({7'd8, 7'd7}));
    #1 chk("lit_c3_ready", 64'(ready), 64'b0011);
    step();
    chk("lit_c3_waddr", 64'(o_waddr), 64'({7'd6, 7'd5}));
    step();

    valid = '0;
    set_req(2, 1'b1, 9, 32'hDEADBEEF);
    #1 chk("lit_single_ready", 64'(ready), 64'b0100);
    step();
    chk("lit_single_we", 64'(o_we), 64'b01);
    chk("lit_single_waddr0", 64'(o_waddr[WR-1:0]), 64'd9);
    chk("lit_single_wdata0", 64'(o_wdata[31:0]), 64'hDEADBEEF);
    chk("lit_single_wdest", 64'(o_wdest), 64'({7'd0, 7'd9}));

    all_valid();
    en = 1'b0;
    #1 chk("lit_stall_ready", 64'(ready), 64'b0000);
    step();
    chk("lit_stall_we", 64'(o_we), 64'b00);
    step();
    en = 1'b1;
    #1 chk("lit_resume_ready", 64'(ready), 64'b1001);
    step();
    chk("lit_resume_waddr", 64'(o_waddr), 64'({7'd5, 7'd8}));

    valid = '0;
    set_req(1, 1'b1, 0, 32'h0000_0011);
    set_req(3, 1'b1, 12, 32'h0000_0033);
    #1 chk("lit_p0_ready", 64'(ready), 64'b1010);
    step();
    chk("lit_p0_we", 64'(o_we), 64'b10);
    chk("lit_p0_wdest", 64'(o_wdest), 64'({7'd12, 7'd0}));
    chk("lit_p0_waddr1", 64'(o_waddr[2*WR-1:WR]), 64'd12);

`ifdef WBARB_KILL_EN
    valid = '0;
    set_req(0, 1'b1, 5, 32'h1000);
    set_req(1, 1'b1, 6, 32'h1001);
    set_req(2, 1'b1, 7, 32'h1002);
    brmask[0*WB +: WB] = 3'b010;
    brkill = 3'b010;
    #1 chk("lit_kill_ready", 64'(ready), 64'b0111);
    step();
    chk("lit_kill_we", 64'(o_we), 64'b11);
    chk("lit_kill_waddr", 64'(o_waddr), 64'({7'd7, 7'd6}));
    valid = 4'b0001;
    en = 1'b0;
    #1 chk("lit_kill_stall_ready", 64'(ready), 64'b0001);
    step();
    chk("lit_kill_stall_we", 64'(o_we), 64'b00);
    en = 1'b1;
    brmask = '0;
    brkill = '0;
`endif

    for (int n = 0; n < 40; n++) begin
      en = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < NREQ; r++)
        set_req(r, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom);
`ifdef WBARB_KILL_EN
      brmask = ($urandom_range(0, 3) == 0) ? NREQ*WB'($urandom) : '0;
      brkill = WB'($urandom);
`endif
      step();
    end
    brmask = '0;
    brkill = '0;

    en = 1'b1;
    all_valid();
    step();
    rst_n = 1'b0;
    #1 chk("lit_midrst_we", 64'(o_we), 64'b00);
    chk("lit_midrst_ready", 64'(ready), 64'b0000);
    step();
    rst_n = 1'b1;
    #1 chk("lit_post_rst_ready", 64'(ready), 64'b0011);
    step();
    chk("lit_post_rst_waddr", 64'(o_waddr), 64'({7'd6, 7'd5}));
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the physical register file write ports between the execute units (MEM, ALU0, ALU1, MulDiv) using a round-robin scheme.
- Each execute unit presents a writeback request with a valid/ready handshake. Granted requests are registered onto the write ports.
- The same registered result is driven as the wakeup/wdest broadcast to the busy table and the issue queues.
- Sits between the execute stage and the regfile write side.

Parameters:
- NREQ, 4, number of requesting execute units.
- NPORT, 2, number of regfile write ports served; must satisfy 1 <= NPORT <= NREQ.
- WIDTH_REG, 7, physical register address width.
- WIDTH_BRM, 3, branch mask width (used only with the optional feature).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_en  input  1  arbitration enable; low means the regfile ports are stalled.
- i_req_valid  input  NREQ  request valid, one bit per requester.
- i_req_addr  input  NREQ*WIDTH_REG  destination PRD; requester r occupies slice [r*WIDTH_REG +: WIDTH_REG].
- i_req_data  input  NREQ*32  result data; requester r occupies slice [r*32 +: 32].
- o_req_ready  output  NREQ  combinational grant/accept, one bit per requester.
- o_we  output  NPORT  registered write enable per port.
- o_waddr  output  NPORT*WIDTH_REG  registered write address per port.
- o_wdata  output  NPORT*32  registered write data per port.
- o_wdest  output  NPORT*WIDTH_REG  wakeup tag per port; equals o_waddr when o_we is 1, otherwise 0.

Behaviour:
- Reset (async, i_rst_n=0):
  - o_we=0, o_waddr=0, o_wdata=0, o_wdest=0.
  - Round-robin pointer rr=0.
  - o_req_ready=0 while in reset.
- Handshake:
  - A transfer occurs when i_req_valid[r] & o_req_ready[r] in the same cycle.
  - A requester must hold valid, addr and data stable until it is accepted.
  - o_req_ready never asserts without the matching valid.
- Grant (combinational), when i_en=1:
  - Scan requesters in the order rr, rr+1, ..., wrapping modulo NREQ.
  - The first NPORT valid requesters are granted.
  - The k-th granted requester in scan order maps to port k.
- Stall: when i_en=0, no grants are made and rr holds.
- Latency: exactly 1 cycle. A request accepted in cycle t appears on o_we/o_waddr/o_wdata/o_wdest in cycle t+1.
- Port outputs at each edge:
  - A port with no grant loads o_we=0. Its addr/data hold their previous values; o_wdest=0.
  - Address 0 (p0, hardwired zero) is accepted normally but loads o_we=0 and o_wdest=0.
- Pointer update at each edge:
  - If at least one grant was made, rr becomes (index of last granted requester + 1) mod NREQ.
  - Otherwise rr holds.
- Fairness: a continuously valid requester is accepted within ceil(NREQ/NPORT) cycles of enabled operation.
- Boundaries:
  - Fewer valid requests than NPORT: all are granted; the unused upper ports load o_we=0.
  - rr wraps from NREQ-1 to 0.
  - Reset asserted mid-operation: outputs clear immediately and any in-flight request is dropped. Requesters re-present after reset.

Optional Feature:
- Macro: WBARB_KILL_EN.
- With the macro defined, two extra inputs are added:
  - i_req_brmask, input, NREQ*WIDTH_BRM.
  - i_brkill, input, WIDTH_BRM.
- Kill rule: a valid request with (brmask & i_brkill) != 0 is killed.
  - It receives o_req_ready=1 in that cycle, independent of i_en and port availability.
  - It consumes no port, causes no write, and does not affect rr.
  - Port outputs already registered are not affected by a later kill.
- Without the macro: the ports are absent and no request is ever killed.

Test Plan:
- Reset: hold i_rst_n=0 with all valid=1 -> o_req_ready=0000, o_we=00, o_wdest=0. Release reset -> first grant goes to requesters 0 and 1.
- All four valid continuously, distinct addr 5/6/7/8 -> cycle 1 grants 0,1; cycle 2 grants 2,3; cycle 3 grants 0,1. o_waddr shows {6,5} then {8,7}, one cycle after each grant.
- Only requester 2 valid (addr 9, data 0xDEADBEEF), rr=0 -> ready=0100. Next cycle o_we=01, o_waddr[0]=9, o_wdata[0]=0xDEADBEEF, o_wdest[0]=9, and rr becomes 3.
- i_en=0 for 2 cycles with all valid -> ready=0000, o_we=00, rr unchanged. On return to i_en=1, grants resume from the same rr.
- Requester 1 with addr 0, requester 3 with addr 12 -> both accepted. Port0: o_we=0, o_wdest=0. Port1: o_we=1, o_waddr=12.
- With WBARB_KILL_EN: requesters 0,1,2 valid, req0 brmask=010, i_brkill=010 -> ready=0111. Ports carry requesters 1 and 2; requester 0 is not written.
